fadd_arb: RTL and testbench

Round-robin arbiter and result router that shares one 3-stage `fadd` pipeline among `NREQ` requesters. Each cycle it accepts at most one operand pair and drives it into the `fadd` inputs. It tracks the requester ID alongside the operation through a tag pipeline whose depth matches the `fadd` latency, then returns the sum with a valid strobe and the originating ID. It sits between the FPU issue logic and the single shared adder instance.

---
 rtl/fadd_arb.sv | 125 ++++++++++++
 tb/tb_fadd_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_arb.sv
// Round-robin arbiter and result router sharing one LAT-stage fadd pipeline among NREQ requesters.
// Optional macro FADD_ARB_SUB_EN: req_op=1 flips the sign of operand 2 so the adder computes x1-x2.
module fadd_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  localparam int IDW = $clog2(NREQ),
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [32*NREQ-1:0]     req_x1,
  input  logic [32*NREQ-1:0]     req_x2,
  input  logic [NREQ-1:0]        req_op,
  output logic [NREQ-1:0]        req_ready,
  output logic [31:0]            fadd_x1,
  output logic [31:0]            fadd_x2,
  input  logic [31:0]            fadd_y,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [31:0]            res_y,
  output logic [CW-1:0]          inflight
);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           grant_any;
  logic [31:0]    x1_arr [NREQ];
  logic [31:0]    x2_arr [NREQ];
  logic           tag_v_reg  [LAT];
  logic [IDW-1:0] tag_id_reg [LAT];
  logic [CW-1:0]  inflight_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign x1_arr[gi]    = req_x1[32*gi +: 32];
      assign x2_arr[gi]    = req_x2[32*gi +: 32];
      assign req_ready[gi] = grant_any && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Search from ptr+1 so the last winner drops to lowest priority; nothing is granted during reset.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_reg) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  always_comb begin
    fadd_x1 = '0;
    fadd_x2 = '0;
    if (grant_any) begin
      fadd_x1 = x1_arr[grant_idx];
      fadd_x2 = x2_arr[grant_idx];
`ifdef FADD_ARB_SUB_EN
      if (req_op[grant_idx]) begin
        fadd_x2 = {~x2_arr[grant_idx][31], x2_arr[grant_idx][30:0]};
      end
`endif
    end
  end

`ifdef FADD_ARB_SUB_EN
`else
  logic unused_op;
  assign unused_op = ^req_op;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= IDW'(NREQ - 1);
    end else if (grant_any) begin
      ptr_reg <= grant_idx;
    end
  end

  // Tag pipeline mirrors the adder depth so the id lines up with fadd_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        tag_v_reg[s]  <= 1'b0;
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_v_reg[0]  <= grant_any;
      tag_id_reg[0] <= grant_idx;
      for (int s = 1; s < LAT; s++) begin
        tag_v_reg[s]  <= tag_v_reg[s-1];
        tag_id_reg[s] <= tag_id_reg[s-1];
      end
    end
  end

  assign res_valid = tag_v_reg[LAT-1];
  assign res_id    = tag_id_reg[LAT-1];
  assign res_y     = fadd_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= '0;
    end else begin
      case ({grant_any, res_valid})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  assign inflight = inflight_reg;

endmodule

// File: tb/tb_fadd_arb.sv
// Randomized bench for fadd_arb: a behavioural 3-stage FP adder plus a cycle-indexed issue history
// from which grants, operands, results and in-flight counts are predicted.
module tb_fadd_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int MAXC = 4096;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_op = '0;
  logic [32*NREQ-1:0]   req_x1 = '0;
  logic [32*NREQ-1:0]   req_x2 = '0;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          fadd_x1, fadd_x2, res_y;
  logic [31:0]          fadd_y = '0;
  logic                 res_valid;
  logic [1:0]           res_id;
  logic [1:0]           inflight;

  always #5 clk = ~clk;

  fadd_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
    .req_op(req_op), .req_ready(req_ready), .fadd_x1(fadd_x1), .fadd_x2(fadd_x2),
    .fadd_y(fadd_y), .res_valid(res_valid), .res_id(res_id), .res_y(res_y), .inflight(inflight)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] i2f(input int n);
    return r2f($itor(n));
  endfunction

  // Stand-in for the shared adder: three register stages, no reset.
  logic [31:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1     <= fp_add(fadd_x1, fadd_x2);
    a2     <= a1;
    fadd_y <= a2;
  end

  bit          iss_v  [MAXC];
  int          iss_id [MAXC];
  logic [31:0] iss_y  [MAXC];
  int cyc = 0, live_from = 0, ptr_m = NREQ - 1;
  int total = 0, bad = 0, res_cnt = 0, last_res_id = 0;
  logic [31:0] last_res_y = '0;
  int gq[$];
  int rq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
  endtask

  // One clock cycle: apply inputs, check all outputs at the falling edge, advance the model.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] op, input bit r);
    int g, t, cnt;
    logic [31:0] ex1, ex2;
    bit ev;
    req_valid = v;
    req_op    = op;
    rst       = r;
    @(negedge clk);
    t = cyc;
    if (r) begin
      live_from = t + 1;
      ptr_m     = NREQ - 1;
    end
    g = -1;
    if (!r) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    ex1 = '0;
    ex2 = '0;
    if (g >= 0) begin
      ex1 = req_x1[32*g +: 32];
      ex2 = req_x2[32*g +: 32];
`ifdef FADD_ARB_SUB_EN
      if (op[g]) ex2[31] = ~ex2[31];
`endif
    end
    check("fadd_x1", fadd_x1, ex1);
    check("fadd_x2", fadd_x2, ex2);
    ev = 1'b0;
    if (t - LAT >= live_from) ev = iss_v[t-LAT];
    check("res_valid", 32'(res_valid), 32'(ev));
    if (ev) begin
      check("res_id", 32'(res_id), iss_id[t-LAT]);
      check("res_y", res_y, iss_y[t-LAT]);
    end
    if (r) check("res_id_rst", 32'(res_id), 32'd0);
    if (res_valid) begin
      $display("cycle %0d: result id=%0d y=%08h inflight=%0d", t, res_id, res_y, inflight);
      last_res_y  = res_y;
      last_res_id = int'(res_id);
      res_cnt++;
      rq.push_back(int'(res_id));
    end
    cnt = 0;
    for (int s = t - LAT; s < t; s++) begin
      if (s >= live_from && iss_v[s]) cnt++;
    end
    check("inflight", 32'(inflight), cnt);
    iss_v[t] = (g >= 0);
    if (g >= 0) begin
      iss_id[t] = g;
      iss_y[t]  = fp_add(ex1, ex2);
      ptr_m     = g;
    end
    gq.push_back(g);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
  endtask

  initial begin
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);

    // single add from requester 1
    set_ops(1, 32'h40400000, 32'h40000000);
    cycle(4'b0010, 4'b0000, 1'b0);
    idle(4);
    check("single_id", last_res_id, 32'd1);
    check("single_y", last_res_y, 32'h40A00000);

    // round-robin fairness straight out of reset
    cycle('0, '0, 1'b1);
    for (int i = 0; i < NREQ; i++) set_ops(i, i2f(i + 1), i2f(10 * i));
    gq.delete();
    rq.delete();
    for (int i = 0; i < 8; i++) cycle(4'b1111, 4'b0000, 1'b0);
    idle(LAT);
    check("rr_grants", gq.size(), 32'd11);
    check("rr_results", rq.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < gq.size()) check("rr_grant_seq", gq[i], i % NREQ);
      if (i < rq.size()) check("rr_id_seq", rq[i], i % NREQ);
    end

    // skip and hold: only 0 and 2 valid after ptr lands on 0
    cycle('0, '0, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b0);
    gq.delete();
    for (int i = 0; i < 3; i++) cycle(4'b0101, 4'b0000, 1'b0);
    check("skip_g0", gq[0], 32'd2);
    check("skip_g1", gq[1], 32'd0);
    check("skip_g2", gq[2], 32'd2);
    idle(LAT);

    // subtract request from requester 3
    set_ops(3, 32'h40400000, 32'h40000000);
    cycle(4'b1000, 4'b1000, 1'b0);
    idle(4);
    check("sub_id", last_res_id, 32'd3);
`ifdef FADD_ARB_SUB_EN
    check("sub_y", last_res_y, 32'h3F800000);
`else
    check("sub_y", last_res_y, 32'h40A00000);
`endif

    // reset while operations are in flight
    cycle('0, '0, 1'b1);
    res_cnt = 0;
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b1);
    gq.delete();
    cycle(4'b1111, 4'b0000, 1'b0);
    check("midrst_next_grant", gq[0], 32'd0);
    idle(4);
    check("midrst_results", res_cnt, 32'd1);

    // idle gaps between issues
    cycle('0, '0, 1'b1);
    res_cnt = 0;
    set_ops(0, 32'h3F800000, 32'h3F800000);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    idle(4);
    check("gap_results", res_cnt, 32'd3);

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i, i2f(int'($urandom_range(0, 200))), i2f(int'($urandom_range(0, 200))));
      end
      cycle(NREQ'($urandom), NREQ'($urandom), ($urandom_range(0, 39) == 0));
    end
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
